// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers:
// stage-state encoding, default widths and control-bundle bit positions.
package pipe_pkg;

  localparam int DEF_DATA_W  = 128;
  localparam int DEF_CTRL_W  = 16;
  localparam int DEF_CNT_W   = 16;
  localparam int FLUSH_CNT_W = 8;

  typedef logic [1:0] stage_state_t;

  localparam stage_state_t ST_EMPTY = 2'd0;
  localparam stage_state_t ST_HALF  = 2'd1;
  localparam stage_state_t ST_FULL  = 2'd2;

  // Control-bundle bit positions shared by every stage
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MWRITE    = 1;
  localparam int CTRL_MREAD     = 2;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_MEMTOREG  = 4;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGDST    = 6;
  localparam int CTRL_JUMP      = 7;
  localparam int CTRL_ALUOP_LSB = 8;
  localparam int CTRL_ALUOP_W   = 4;

  function automatic logic [1:0] state_occupancy(input stage_state_t s);
    case (s)
      ST_HALF: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_counter.sv
// Event counter with selectable saturate-at-all-ones or wrap-around behaviour.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int W        = DEF_CNT_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (inc_i && !(SATURATE && (&count_q))) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with optional 2-entry skid buffer,
// bubble-zeroed control bundle, flush, and stall/flush debug counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [1:0]             occupancy,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  stage_state_t      state_q,  state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    if (flush) begin
      state_d  = ST_EMPTY;
      m_data_d = '0;
      m_ctrl_d = '0;
      s_data_d = '0;
      s_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
            state_d  = ST_HALF;
          end
        end
        ST_HALF: begin
          if (in_fire && out_fire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (in_fire && SKID) begin
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
            state_d  = ST_FULL;
          end else if (out_fire) begin
            m_data_d = '0;
            m_ctrl_d = '0;
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            s_data_d = '0;
            s_ctrl_d = '0;
            state_d  = ST_HALF;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the payload registers sit on the async reset too, so outputs read zero
  // the moment reset asserts rather than showing stale data until the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
    end
  end

  if (SKID) begin : g_skid_ready
    logic ready_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) ready_q <= 1'b1;
      else     ready_q <= (state_d != ST_FULL);
    end
    assign in_ready = ready_q;
  end else begin : g_comb_ready
    assign in_ready = ~out_valid | out_ready;
  end

  // Control is masked on bubbles so downstream write enables stay inert.
  assign out_data  = m_data_q;
  assign out_ctrl  = out_valid ? m_ctrl_q : '0;
  assign occupancy = state_occupancy(state_q);

  pipe_sat_counter #(.W(CNT_W), .SATURATE(1'b1)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (out_valid & ~out_ready),
    .count_o (stall_cnt)
  );

  pipe_sat_counter #(.W(FLUSH_CNT_W), .SATURATE(1'b0)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flush & out_valid),
    .count_o (flush_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core.
- Replaces hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Carries an opaque data bundle plus a control bundle that is zeroed for bubbles, using a valid/ready handshake with an optional 2-entry skid buffer.
- Flush squashes all contents; stall and occupancy counters support performance debug.

Parameters:
- DATA_W, 128, width of payload bundle (PC, operands, immediates, register indices).
- CTRL_W, 16, width of control bundle (RegWrite, Mwrite, Mread, Branch, ALUop...); forced 0 whenever the entry is invalid.
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready).
- CNT_W, 16, width of saturating stall-cycle counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- flush  in  1  synchronous squash of all held entries (branch taken / exception)
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  held payload
- out_ctrl  out  CTRL_W  held control; 0 when out_valid=0
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0
- flush_cnt  out  8  wrapping count of flush cycles that discarded at least one valid entry

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, flush_cnt=0.
  - Skid entry invalid and zeroed.
  - in_ready=1 when SKID=1; in_ready follows the comb rule below when SKID=0.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Data is never dropped or duplicated absent flush.
- Latency: 1 cycle. An entry accepted at edge N is on out_* after edge N when the stage was EMPTY or drained.
- State machine (M = main/out register, S = skid register):
  - EMPTY: in_fire -> HALF (M<=in).
  - HALF, in_fire & out_fire -> HALF (M<=in).
  - HALF, in_fire & !out_fire -> FULL (S<=in; SKID=1 only).
  - HALF, !in_fire & out_fire -> EMPTY.
  - HALF, neither -> HALF (hold).
  - FULL: in_ready=0. out_fire -> HALF (M<=S, S invalid). Otherwise hold.
- in_ready:
  - SKID=1: registered, equals (state != FULL).
  - SKID=0: in_ready = !out_valid | out_ready (combinational). FULL is unreachable.
- Flush: highest priority.
  - Next state EMPTY; M and S invalid; data and ctrl zeroed.
  - Any in_fire in the same cycle is discarded.
  - flush_cnt increments iff occupancy!=0 that cycle.
- Bubbles: whenever out_valid=0, out_ctrl=0, so downstream write enables are inert.
- stall_cnt: increments each cycle with out_valid & !out_ready, saturating at all-ones. It is not cleared by flush.
- A reset asserted mid-transfer wins over every other input; no partial update occurs.

Decomposition:
- Shared package pipe_pkg:
  - stage-state enum (ST_EMPTY, ST_HALF, ST_FULL).
  - default widths and CTRL bit-position constants (CTRL_REGWRITE, CTRL_MWRITE, CTRL_MREAD, CTRL_BRANCH, ...) used by all stages.
- Sub-module pipe_sat_counter (parametrised width, inc, saturate/wrap mode). It is instantiated for stall_cnt and flush_cnt.

Test Plan:
- Reset then single transfer:
  - Stimulus: rst pulse mid-cycle; in_valid=1, in_data=0x...A5, in_ctrl=0x0011, out_ready=1.
  - Required: out_valid=1 with those values one edge later; occupancy=1.
- Backpressure skid (SKID=1):
  - Stimulus: out_ready=0; push D1, then D2.
  - Required: occupancy=2, in_ready=0, stall_cnt=2.
  - Then out_ready=1: out_data=D1, then D2, in order; in_ready=1 after the first out_fire.
- SKID=0 back-to-back:
  - Stimulus: stream 0..7 with out_ready=1.
  - Required: one item per cycle, in_ready never drops.
  - Then out_ready=0: in_ready=0 combinationally in the same cycle.
- Flush with full buffer:
  - Stimulus: occupancy=2 plus in_fire and flush=1 on the same edge.
  - Required: out_valid=0, out_ctrl=0, occupancy=0, flush_cnt=1, new input lost.
  - Flush when EMPTY: flush_cnt unchanged.
- Saturation:
  - Stimulus: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles.
  - Required: stall_cnt=15, no wrap.
- Reset mid-stream:
  - Stimulus: assert rst while FULL between clock edges.
  - Required: all outputs zero immediately; first post-reset push appears after 1 edge.
